// File: rtl/pipelined_adder_pkg.sv
// Shared defaults and chunk geometry for the pipelined lane adder.
package pipelined_adder_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_NUM_REGS   = 2;
  localparam int unsigned DEF_NUM_LANES  = 2;

  function automatic int unsigned chunk_width(input int unsigned n, input int unsigned r);
    return (n + r - 1) / r;
  endfunction

  // Offset clamps at n: stages past the top bit get an empty chunk and only delay.
  function automatic int unsigned chunk_off(input int unsigned n, input int unsigned r,
                                            input int unsigned i);
    int unsigned off;
    off = i * chunk_width(n, r);
    return (off > n) ? n : off;
  endfunction

  function automatic int unsigned chunk_len(input int unsigned n, input int unsigned r,
                                            input int unsigned i);
    int unsigned rem;
    rem = n - chunk_off(n, r, i);
    return (rem < chunk_width(n, r)) ? rem : chunk_width(n, r);
  endfunction

endpackage

// File: rtl/adder_chunk_stage.sv
// One registered CW-bit chunk add; o_sum carries {carry_out, sum}.
module adder_chunk_stage #(
  parameter int unsigned CW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_en,
  input  logic [CW-1:0] i_a,
  input  logic [CW-1:0] i_b,
  input  logic          i_cin,
  output logic [CW:0]   o_sum
);

  logic [CW:0] r_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum <= '0;
    end else if (i_en) begin
      r_sum <= (CW+1)'(i_a) + (CW+1)'(i_b) + (CW+1)'(i_cin);
    end
  end

  assign o_sum = r_sum;

endmodule

// File: rtl/pipelined_lane_adder.sv
// Multi-lane add/subtract with the carry chain split across num_regs stages,
// operand skew and result deskew registers, and a valid/ready pipeline.
module pipelined_lane_adder
  import pipelined_adder_pkg::*;
#(
  parameter int unsigned inp_data_width = DEF_DATA_WIDTH,
  parameter int unsigned num_regs       = DEF_NUM_REGS,
  parameter int unsigned num_lanes      = DEF_NUM_LANES
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       in_valid,
  output logic                                       in_ready,
  input  logic                                       in_sub,
  input  logic [num_lanes*inp_data_width-1:0]        inp1,
  input  logic [num_lanes*inp_data_width-1:0]        inp2,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic [num_lanes*(inp_data_width+1)-1:0]    outp,
  output logic                                       busy
);

  localparam int unsigned W  = inp_data_width;
  localparam int unsigned R  = num_regs;
  localparam int unsigned L  = num_lanes;
  localparam int unsigned N  = W + 1;
  localparam int unsigned C  = chunk_width(N, R);
  localparam int unsigned TW = N + C + 1;

  logic         w_en;
  logic [R-1:0] r_valid;

  assign w_en      = out_ready | ~r_valid[R-1];
  assign in_ready  = w_en;
  assign out_valid = r_valid[R-1];
  assign busy      = |r_valid;

  // Bubbles shift through as cleared valid bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
    end else if (w_en) begin
      r_valid <= R'({r_valid, in_valid});
    end
  end

  for (genvar k = 0; k < L; k++) begin : g_lane
    logic [N-1:0] w_a_src [R];
    logic [N-1:0] w_b_src [R];
    logic [N-1:0] w_done  [R];
    logic [N-1:0] w_res   [R];
    logic         w_cin   [R];

    // Subtract is folded in up front: B inverted here, +1 via stage-0 carry.
    assign w_a_src[0] = N'(inp1[k*W +: W]);
    assign w_b_src[0] = in_sub ? ~N'(inp2[k*W +: W]) : N'(inp2[k*W +: W]);
    assign w_done[0]  = '0;
    assign w_cin[0]   = in_sub;

    for (genvar i = 0; i < R; i++) begin : g_stage
      localparam int unsigned OFF = chunk_off(N, R, i);
      localparam int unsigned LEN = chunk_len(N, R, i);
      localparam int unsigned CWI = (LEN == 0) ? 1 : LEN;
      localparam logic [TW-1:0] MASK = ~({TW{1'b1}} << LEN);

      logic [CWI:0]  w_sum;
      logic [TW-1:0] w_place;

      adder_chunk_stage #(.CW(CWI)) u_chunk (
        .clk   (clk),
        .rst_n (rst_n),
        .i_en  (w_en),
        .i_a   (CWI'(w_a_src[i] >> OFF)),
        .i_b   (CWI'(w_b_src[i] >> OFF)),
        .i_cin (w_cin[i]),
        .o_sum (w_sum)
      );

      // Only the chunk's own sum bits land in the result; the carry moves on.
      assign w_place  = (TW'(w_sum) & MASK) << OFF;
      assign w_res[i] = w_done[i] | N'(w_place);

      if (i == R - 1) begin : g_out
        assign outp[k*N +: N] = w_res[i];
      end else begin : g_skew
        logic [N-1:0] r_a;
        logic [N-1:0] r_b;
        logic [N-1:0] r_res;

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_res <= '0;
          end else if (w_en) begin
            r_a   <= w_a_src[i];
            r_b   <= w_b_src[i];
            r_res <= w_res[i];
          end
        end

        assign w_a_src[i+1] = r_a;
        assign w_b_src[i+1] = r_b;
        assign w_done[i+1]  = r_res;
        assign w_cin[i+1]   = w_sum[CWI];
      end
    end
  end

endmodule
